// File: rtl/io_pkg.sv
// Shared widths, FIFO sizing and the input-holding-register state type for the IO port unit.
package io_pkg;

  localparam int IO_DATA_W     = 16;
  localparam int IO_FIFO_DEPTH = 4;
  localparam int IO_PTR_W      = 2;
  localparam int IO_CNT_W      = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } in_state_t;

endpackage

// File: rtl/io_fifo.sv
// Output queue for the IO port unit: circular buffer of DEPTH words with a valid/ready
// pop side. A pop in the same cycle frees a slot, so a push into a full queue still lands.
module io_fifo
  import io_pkg::*;
#(
  parameter int DEPTH = IO_FIFO_DEPTH,
  parameter int W     = IO_DATA_W
) (
  input  logic                CLK,
  input  logic                Reset_n,
  input  logic                push,
  input  logic [W-1:0]        push_data,
  input  logic                pop_ready,
  output logic [W-1:0]        head_data,
  output logic                head_valid,
  output logic [IO_CNT_W-1:0] count,
  output logic                overflow
);

  localparam logic [IO_CNT_W-1:0] DEPTH_C = IO_CNT_W'(DEPTH);

  logic [IO_CNT_W-1:0] count_reg;
  logic [IO_CNT_W-1:0] count_next;
  logic                full;
  logic                pop;
  logic                push_ok;

  assign full       = (count_reg == DEPTH_C);
  assign head_valid = (count_reg != '0);
  assign pop        = head_valid && pop_ready;
  assign push_ok    = push && (!full || pop);
  assign overflow   = push && full && !pop;
  assign count      = count_reg;
  assign count_next = count_reg + {{(IO_CNT_W-1){1'b0}}, push_ok} - {{(IO_CNT_W-1){1'b0}}, pop};

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  generate
    if (DEPTH == 1) begin : g_single
      // One slot: the head is the only entry, no pointers needed.
      logic [W-1:0] data_reg;

      always_ff @(posedge CLK) begin
        if (Reset_n && push_ok) begin
          data_reg <= push_data;
        end
      end

      assign head_data = data_reg;
    end else begin : g_ring
      localparam int PTR_W = (DEPTH == IO_FIFO_DEPTH) ? IO_PTR_W : $clog2(DEPTH);
      localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

      logic [W-1:0]     mem [DEPTH];
      logic [PTR_W-1:0] wr_ptr_reg;
      logic [PTR_W-1:0] rd_ptr_reg;

      always_ff @(posedge CLK) begin
        if (!Reset_n) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
        end else begin
          if (push_ok) begin
            wr_ptr_reg <= (wr_ptr_reg == LAST) ? '0 : wr_ptr_reg + 1'b1;
          end
          if (pop) begin
            rd_ptr_reg <= (rd_ptr_reg == LAST) ? '0 : rd_ptr_reg + 1'b1;
          end
        end
      end

      always_ff @(posedge CLK) begin
        if (Reset_n && push_ok) begin
          mem[wr_ptr_reg] <= push_data;
        end
      end

      assign head_data = mem[rd_ptr_reg];
    end
  endgenerate

endmodule

// File: rtl/io_port_unit.sv
// IO port unit: output queue toward the external channel and a one-word input holding register.
// IO_OUT_FIFO_EN selects a 4-entry output FIFO; without it the output side is a single register.
module io_port_unit
  import io_pkg::*;
(
  input  logic                 CLK,
  input  logic                 Reset_n,
  input  logic                 OutputWrite,
  input  logic [IO_DATA_W-1:0] OutData,
  input  logic                 InRead,
  output logic [IO_DATA_W-1:0] InData,
  output logic                 InAvail,
  output logic [IO_DATA_W-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic [IO_DATA_W-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [IO_CNT_W-1:0]  OutCount,
  output logic                 OutOverflow,
  output logic                 InUnderflow
);

`ifdef IO_OUT_FIFO_EN
  localparam int OUT_DEPTH = IO_FIFO_DEPTH;
`else
  localparam int OUT_DEPTH = 1;
`endif

  logic                 fifo_overflow;
  logic                 overflow_reg;
  logic                 underflow_reg;
  in_state_t            state_reg;
  in_state_t            state_next;
  logic [IO_DATA_W-1:0] held_reg;
  logic                 capture;

  io_fifo #(
    .DEPTH (OUT_DEPTH),
    .W     (IO_DATA_W)
  ) u_out_fifo (
    .CLK       (CLK),
    .Reset_n   (Reset_n),
    .push      (OutputWrite),
    .push_data (OutData),
    .pop_ready (out_ready),
    .head_data (out_data),
    .head_valid(out_valid),
    .count     (OutCount),
    .overflow  (fifo_overflow)
  );

  // A read while FULL reopens the slot in the same cycle, so a new word can be captured at once.
  always_comb begin
    state_next = state_reg;
    in_ready   = (state_reg == EMPTY) || InRead;
    capture    = in_valid && in_ready;
    case (state_reg)
      EMPTY: if (capture) state_next = FULL;
      FULL: begin
        if (capture)     state_next = FULL;
        else if (InRead) state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state_reg     <= EMPTY;
      held_reg      <= '0;
      underflow_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (capture) begin
        held_reg <= in_data;
      end
      if (InRead && (state_reg == EMPTY)) begin
        underflow_reg <= 1'b1;
      end
      if (fifo_overflow) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign InAvail     = (state_reg == FULL);
  assign InData      = (state_reg == FULL) ? held_reg : '0;
  assign OutOverflow = overflow_reg;
  assign InUnderflow = underflow_reg;

endmodule

// File: tb/tb_io_port_unit.sv
// Self-checking bench for io_port_unit; the output side is scored against a queue model
// sized to match the IO_OUT_FIFO_EN build option.
module tb_io_port_unit;

`ifdef IO_OUT_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        CLK = 1'b0;
  logic        Reset_n;
  logic        OutputWrite;
  logic [15:0] OutData;
  logic        InRead;
  logic [15:0] InData;
  logic        InAvail;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  OutCount;
  logic        OutOverflow;
  logic        InUnderflow;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic        exp_ovf;

  io_port_unit dut (
    .CLK(CLK), .Reset_n(Reset_n), .OutputWrite(OutputWrite), .OutData(OutData),
    .InRead(InRead), .InData(InData), .InAvail(InAvail),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .OutCount(OutCount), .OutOverflow(OutOverflow), .InUnderflow(InUnderflow)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One output-side cycle: score any pop against the queue head, then model the push.
  task automatic out_cycle(input logic wr, input logic [15:0] d, input logic rdy);
    logic popped;
    logic [15:0] e;
    popped = 1'b0;
    OutputWrite = wr;
    OutData     = d;
    out_ready   = rdy;
    #1;
    if (rdy && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      popped = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== e) begin
        errors++;
        $display("FAIL pop_data: got valid=%b data=%h, expected valid=1 data=%h", out_valid, out_data, e);
      end
    end
    if (wr) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else exp_ovf = 1'b1;
    end
    $display("out cycle wr=%b d=%h rdy=%b pop=%b model_count=%0d", wr, d, rdy, popped, exp_q.size());
    step();
    OutputWrite = 1'b0;
    out_ready   = 1'b0;
    checks++;
    if (OutCount !== 3'(exp_q.size()) || out_valid !== (exp_q.size() != 0) || OutOverflow !== exp_ovf) begin
      errors++;
      $display("FAIL out_state: got count=%0d valid=%b ovf=%b, expected count=%0d valid=%b ovf=%b",
               OutCount, out_valid, OutOverflow, exp_q.size(), exp_q.size() != 0, exp_ovf);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2 && exp_q.size() != 0; i++) out_cycle(1'b0, 16'h0, 1'b1);
    checks++;
    if (exp_q.size() != 0 || OutCount !== 3'd0) begin
      errors++;
      $display("FAIL drain: got count=%0d, expected 0 with %0d model entries left", OutCount, exp_q.size());
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; OutputWrite = 1'b1; OutData = 16'hDEAD; out_ready = 1'b0;
    InRead = 1'b0; in_valid = 1'b1; in_data = 16'hBEEF;
    step();
    Reset_n = 1'b1; OutputWrite = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    $display("reset applied");
    checks++;
    if (OutCount !== 3'd0 || out_valid !== 1'b0 || InAvail !== 1'b0 || InData !== 16'h0 ||
        in_ready !== 1'b1 || OutOverflow !== 1'b0 || InUnderflow !== 1'b0) begin
      errors++;
      $display("FAIL reset: got cnt=%0d ov=%b avail=%b indata=%h rdy=%b ovf=%b udf=%b, expected 0 0 0 0000 1 0 0",
               OutCount, out_valid, InAvail, InData, in_ready, OutOverflow, InUnderflow);
    end
  endtask

  task automatic test_single_push();
    out_cycle(1'b1, 16'h00A5, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h00A5 || OutCount !== 3'd1) begin
      errors++;
      $display("FAIL single_push: got valid=%b data=%h cnt=%0d, expected 1 00a5 1", out_valid, out_data, OutCount);
    end
    drain();
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) out_cycle(1'b1, 16'(i), 1'b0);
    checks++;
    if (OutCount !== 3'(DEPTH) || OutOverflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow: got cnt=%0d ovf=%b, expected cnt=%0d ovf=1", OutCount, OutOverflow, DEPTH);
    end
    drain();
  endtask

  task automatic test_push_pop_full();
    for (int i = 0; i < DEPTH; i++) out_cycle(1'b1, 16'h0010 + 16'(i), 1'b0);
    out_cycle(1'b1, 16'h0009, 1'b1);
    checks++;
    if (OutCount !== 3'(DEPTH) || OutOverflow !== 1'b0) begin
      errors++;
      $display("FAIL push_pop_full: got cnt=%0d ovf=%b, expected cnt=%0d ovf=0", OutCount, OutOverflow, DEPTH);
    end
    drain();
  endtask

  task automatic test_input_capture();
    in_valid = 1'b1; in_data = 16'h1234;
    step();
    in_valid = 1'b0;
    $display("in capture 1234");
    checks++;
    if (InAvail !== 1'b1 || InData !== 16'h1234 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL capture: got avail=%b data=%h rdy=%b, expected 1 1234 0", InAvail, InData, in_ready);
    end
    InRead = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || InData !== 16'h1234) begin
      errors++;
      $display("FAIL read_cycle: got rdy=%b data=%h, expected 1 1234", in_ready, InData);
    end
    step();
    InRead = 1'b0;
    $display("in read");
    checks++;
    if (InAvail !== 1'b0 || in_ready !== 1'b1 || InData !== 16'h0) begin
      errors++;
      $display("FAIL consume: got avail=%b rdy=%b data=%h, expected 0 1 0000", InAvail, in_ready, InData);
    end
  endtask

  task automatic test_underflow();
    InRead = 1'b1;
    #1;
    checks++;
    if (InData !== 16'h0) begin
      errors++;
      $display("FAIL empty_data: got %h, expected 0000", InData);
    end
    step();
    InRead = 1'b0;
    $display("in read while empty");
    checks++;
    if (InUnderflow !== 1'b1 || InAvail !== 1'b0) begin
      errors++;
      $display("FAIL underflow: got udf=%b avail=%b, expected 1 0", InUnderflow, InAvail);
    end
    in_valid = 1'b1; in_data = 16'h1111;
    step();
    in_valid = 1'b0; InRead = 1'b1;
    step();
    InRead = 1'b0;
    $display("in capture 1111 then read");
    checks++;
    if (InUnderflow !== 1'b1 || InAvail !== 1'b0) begin
      errors++;
      $display("FAIL underflow_sticky: got udf=%b avail=%b, expected 1 0", InUnderflow, InAvail);
    end
    test_reset();
    InRead = 1'b1; in_valid = 1'b1; in_data = 16'hABCD;
    step();
    InRead = 1'b0; in_valid = 1'b0;
    $display("in read while empty with capture abcd");
    checks++;
    if (InUnderflow !== 1'b1 || InAvail !== 1'b1 || InData !== 16'hABCD) begin
      errors++;
      $display("FAIL underflow_capture: got udf=%b avail=%b data=%h, expected 1 1 abcd", InUnderflow, InAvail, InData);
    end
    test_reset();
  endtask

  task automatic test_recapture();
    in_valid = 1'b1; in_data = 16'h1111;
    step();
    InRead = 1'b1; in_data = 16'h5678;
    step();
    InRead = 1'b0; in_valid = 1'b0;
    $display("in read with recapture 5678");
    checks++;
    if (InAvail !== 1'b1 || InData !== 16'h5678 || InUnderflow !== 1'b0) begin
      errors++;
      $display("FAIL recapture: got avail=%b data=%h udf=%b, expected 1 5678 0", InAvail, InData, InUnderflow);
    end
    InRead = 1'b1;
    step();
    InRead = 1'b0;
    checks++;
    if (InAvail !== 1'b0 || InData !== 16'h0) begin
      errors++;
      $display("FAIL recapture_empty: got avail=%b data=%h, expected 0 0000", InAvail, InData);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      out_cycle(1'($urandom_range(1)), 16'($urandom), 1'($urandom_range(1)));
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_overflow();
    test_reset();
    test_push_pop_full();
    test_input_capture();
    test_underflow();
    test_recapture();
    test_reset();
    test_back_to_back();
    for (int i = 0; i < 3; i++) out_cycle(1'b1, 16'h7000 + 16'(i), 1'b0);
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_port_unit.md
IO_PORT_UNIT -- requirements
Module: io_port_unit

Interface
REQ-001 SHALL have ports: CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have ports: Reset_n  in  1  reset, synchronous and active-low.
REQ-003 SHALL have ports: OutputWrite  in  1  one-cycle push strobe from control unit "out" state.
REQ-004 SHALL have ports: OutData  in  16  register value pushed on OutputWrite.
REQ-005 SHALL have ports: InRead  in  1  one-cycle consume strobe from control unit "in" state (RegWrite, MemtoReg=2).
REQ-006 SHALL have ports: InData  out  16  input word presented to register-file write mux.
REQ-007 SHALL have ports: InAvail  out  1  input holding register full.
REQ-008 SHALL have ports: out_data  out  16, out_valid  out  1, out_ready  in  1  external output channel; valid/ready handshake.
REQ-009 SHALL have ports: in_data  in  16, in_valid  in  1, in_ready  out  1  external input channel; valid/ready handshake.
REQ-010 SHALL have ports: OutCount  out  3  occupied output-FIFO entries.
REQ-011 SHALL have ports: OutOverflow  out  1, InUnderflow  out  1  sticky error flags.

Function
REQ-012 SHALL implement an output FIFO of depth 4, 16 bits wide, circular 2-bit read/write pointers wrapping 3->0.
REQ-013 SHALL accept a push on OutputWrite when OutCount<4; entry visible on out_data/out_valid the following cycle (1-cycle latency, no bypass).
REQ-014 SHALL drop the push and set OutOverflow when OutputWrite arrives with OutCount=4 and no pop that cycle.
REQ-015 SHALL pop the head when out_valid && out_ready; out_valid = (OutCount!=0); out_data = head entry, stable while out_valid && !out_ready.
REQ-016 SHALL, on simultaneous push and pop, accept both; OutCount unchanged, including when full (pop frees slot first).
REQ-017 SHALL implement input holding register with 2-state FSM: EMPTY -> FULL on in_valid && in_ready; FULL -> EMPTY on InRead without new capture; FULL -> FULL on InRead && in_valid (consume and recapture same cycle).
REQ-018 SHALL drive in_ready = (state==EMPTY) || InRead.
REQ-019 SHALL drive InData = held word when FULL, 16'h0000 when EMPTY; InAvail = (state==FULL).
REQ-020 SHALL set InUnderflow on InRead while EMPTY; state stays EMPTY, no capture that cycle unless in_valid (then capture, flag still set).
REQ-021 SHALL keep OutOverflow and InUnderflow set until reset.

Reset
REQ-022 SHALL, when Reset_n=0 at a rising CLK edge, clear pointers, OutCount=0, out_valid=0, input FSM=EMPTY, InData=0, InAvail=0, both flags=0; in_ready=1 after reset.
REQ-023 SHALL discard all in-flight data on reset mid-operation; a push or capture coincident with reset is lost.

Configuration
REQ-024 SHALL honour macro IO_OUT_FIFO_EN: defined -> 4-entry FIFO per REQ-012..016; undefined -> single 16-bit output register (depth 1), OutCount in {0,1}, overflow rule REQ-014 applied at count=1.

Structure
REQ-025 SHALL take IO_DATA_W=16, IO_FIFO_DEPTH=4, pointer width and input-FSM state enum (EMPTY, FULL) from shared package io_pkg.
REQ-026 SHALL place the output queue in sub-module io_fifo (parameterised by depth); input register and flags stay in io_port_unit.

Verification
REQ-027 SHALL cover: reset, then OutputWrite with OutData=16'h00A5, out_ready=0 -> next cycle out_valid=1, out_data=16'h00A5, OutCount=1.
REQ-028 SHALL cover: 5 consecutive pushes 1..5 with out_ready=0 -> OutCount=4, OutOverflow=1; drain yields 1,2,3,4 in order.
REQ-029 SHALL cover: FIFO full, OutputWrite 16'h0009 with out_ready=1 same cycle -> OutCount stays 4, no overflow, tail=16'h0009.
REQ-030 SHALL cover: in_valid with in_data=16'h1234 -> InAvail=1, InData=16'h1234, in_ready=0; InRead -> InAvail=0, in_ready=1.
REQ-031 SHALL cover: InRead while EMPTY -> InData=0, InUnderflow=1, remains set after later successful reads; Reset_n=0 clears it.
REQ-032 SHALL cover: FULL, InRead and in_valid with 16'h5678 same cycle -> stays FULL, InData=16'h5678 next cycle.
